// File: rtl/id_ex_if.sv
// ID/EX boundary bundle: decode-side instruction fields, writeback bypass
// source, flush, and the registered EX-side copies plus the stall request.
interface id_ex_if #(
  parameter int unsigned XLEN = 32
);
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic            id_uses_rs1;
  logic            id_uses_rs2;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [3:0]      id_alu_op;
  logic            id_alu_src;
  logic            id_mem_read;
  logic            id_mem_write;
  logic            id_reg_write;
  logic            id_mem_to_reg;

  logic            wb_reg_write;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  logic            flush;
  logic            stall;

  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [XLEN-1:0] ex_imm;
  logic [4:0]      ex_rs1;
  logic [4:0]      ex_rs2;
  logic [4:0]      ex_rd;
  logic [3:0]      ex_alu_op;
  logic            ex_alu_src;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic            ex_reg_write;
  logic            ex_mem_to_reg;

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
           id_rs1_data, id_rs2_data, id_imm, id_alu_op, id_alu_src,
           id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg,
           wb_reg_write, wb_rd, wb_data, flush,
    input  stall, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_alu_op, ex_alu_src, ex_mem_read,
           ex_mem_write, ex_reg_write, ex_mem_to_reg
  );

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
           id_rs1_data, id_rs2_data, id_imm, id_alu_op, id_alu_src,
           id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg,
           wb_reg_write, wb_rd, wb_data, flush,
    output stall, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_alu_op, ex_alu_src, ex_mem_read,
           ex_mem_write, ex_reg_write, ex_mem_to_reg
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall (LOAD_LATENCY bubbles per
// hazard), same-cycle writeback bypass and EX-driven flush.
module id_ex_stage #(
  parameter int unsigned LOAD_LATENCY = 1,
  parameter int unsigned XLEN         = 32
) (
  input  logic    clk,
  input  logic    rst,
  id_ex_if.slave  bus
);

  localparam logic [2:0] RELOAD = 3'(LOAD_LATENCY - 1);

  logic [2:0]      stall_cnt;
  logic            haz;
  logic            rs1_hit;
  logic            rs2_hit;
  logic            stall_int;
  logic            wb_fwd_ok;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

  always_comb begin
    rs1_hit   = bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd);
    rs2_hit   = bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd);
    haz       = bus.ex_valid && bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                bus.id_valid && (rs1_hit || rs2_hit);
    stall_int = !bus.flush && (haz || (stall_cnt != 3'd0));
  end

  assign bus.stall = stall_int;

  // Register file writes on posedge but reads combinationally, so a value
  // being written this cycle is not yet visible on id_rsN_data.
  always_comb begin
    wb_fwd_ok = bus.wb_reg_write && (bus.wb_rd != 5'd0);
    rs1_fwd   = (wb_fwd_ok && (bus.wb_rd == bus.id_rs1)) ? bus.wb_data : bus.id_rs1_data;
    rs2_fwd   = (wb_fwd_ok && (bus.wb_rd == bus.id_rs2)) ? bus.wb_data : bus.id_rs2_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (bus.flush) begin
      stall_cnt <= '0;
    end else if (haz) begin
      stall_cnt <= RELOAD;
    end else if (stall_cnt != 3'd0) begin
      stall_cnt <= stall_cnt - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush || stall_int) begin
      bus.ex_valid      <= 1'b0;
      bus.ex_pc         <= '0;
      bus.ex_rs1_data   <= '0;
      bus.ex_rs2_data   <= '0;
      bus.ex_imm        <= '0;
      bus.ex_rs1        <= '0;
      bus.ex_rs2        <= '0;
      bus.ex_rd         <= '0;
      bus.ex_alu_op     <= '0;
      bus.ex_alu_src    <= 1'b0;
      bus.ex_mem_read   <= 1'b0;
      bus.ex_mem_write  <= 1'b0;
      bus.ex_reg_write  <= 1'b0;
      bus.ex_mem_to_reg <= 1'b0;
    end else begin
      bus.ex_valid      <= bus.id_valid;
      bus.ex_pc         <= bus.id_pc;
      bus.ex_rs1_data   <= rs1_fwd;
      bus.ex_rs2_data   <= rs2_fwd;
      bus.ex_imm        <= bus.id_imm;
      bus.ex_rs1        <= bus.id_rs1;
      bus.ex_rs2        <= bus.id_rs2;
      bus.ex_rd         <= bus.id_rd;
      bus.ex_alu_op     <= bus.id_alu_op;
      bus.ex_alu_src    <= bus.id_valid && bus.id_alu_src;
      bus.ex_mem_read   <= bus.id_valid && bus.id_mem_read;
      bus.ex_mem_write  <= bus.id_valid && bus.id_mem_write;
      bus.ex_reg_write  <= bus.id_valid && bus.id_reg_write;
      bus.ex_mem_to_reg <= bus.id_valid && bus.id_mem_to_reg;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: two instances (LOAD_LATENCY 1 and 3) driven with the
// same inputs and compared against a per-instance behavioural model.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic [3:0]  alu_op;
    logic        alu_src, mem_read, mem_write, reg_write, mem_to_reg;
  } ex_t;

  typedef struct packed {
    logic        rst, valid;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic        uses1, uses2;
    logic [31:0] d1, d2, imm;
    logic [3:0]  alu_op;
    logic        alu_src, mem_read, mem_write, reg_write, mem_to_reg;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
  } in_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_if #(.XLEN(32)) u_if1 ();
  id_ex_if #(.XLEN(32)) u_if3 ();

  id_ex_stage #(.LOAD_LATENCY(1), .XLEN(32)) dut1 (.clk(clk), .rst(rst), .bus(u_if1.slave));
  id_ex_stage #(.LOAD_LATENCY(3), .XLEN(32)) dut3 (.clk(clk), .rst(rst), .bus(u_if3.slave));

  in_t cur;
  ex_t m_ex [2];
  int  m_left [2];
  int  ll [2];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic apply();
    rst = cur.rst;
    u_if1.id_valid = cur.valid;      u_if3.id_valid = cur.valid;
    u_if1.id_pc = cur.pc;            u_if3.id_pc = cur.pc;
    u_if1.id_rs1 = cur.rs1;          u_if3.id_rs1 = cur.rs1;
    u_if1.id_rs2 = cur.rs2;          u_if3.id_rs2 = cur.rs2;
    u_if1.id_rd = cur.rd;            u_if3.id_rd = cur.rd;
    u_if1.id_uses_rs1 = cur.uses1;   u_if3.id_uses_rs1 = cur.uses1;
    u_if1.id_uses_rs2 = cur.uses2;   u_if3.id_uses_rs2 = cur.uses2;
    u_if1.id_rs1_data = cur.d1;      u_if3.id_rs1_data = cur.d1;
    u_if1.id_rs2_data = cur.d2;      u_if3.id_rs2_data = cur.d2;
    u_if1.id_imm = cur.imm;          u_if3.id_imm = cur.imm;
    u_if1.id_alu_op = cur.alu_op;    u_if3.id_alu_op = cur.alu_op;
    u_if1.id_alu_src = cur.alu_src;  u_if3.id_alu_src = cur.alu_src;
    u_if1.id_mem_read = cur.mem_read;   u_if3.id_mem_read = cur.mem_read;
    u_if1.id_mem_write = cur.mem_write; u_if3.id_mem_write = cur.mem_write;
    u_if1.id_reg_write = cur.reg_write; u_if3.id_reg_write = cur.reg_write;
    u_if1.id_mem_to_reg = cur.mem_to_reg; u_if3.id_mem_to_reg = cur.mem_to_reg;
    u_if1.wb_reg_write = cur.wb_we;  u_if3.wb_reg_write = cur.wb_we;
    u_if1.wb_rd = cur.wb_rd;         u_if3.wb_rd = cur.wb_rd;
    u_if1.wb_data = cur.wb_data;     u_if3.wb_data = cur.wb_data;
    u_if1.flush = cur.flush;         u_if3.flush = cur.flush;
  endtask

  function automatic ex_t get_act(int k);
    ex_t a;
    if (k == 0)
      a = '{u_if1.ex_valid, u_if1.ex_pc, u_if1.ex_rs1, u_if1.ex_rs2, u_if1.ex_rd,
            u_if1.ex_rs1_data, u_if1.ex_rs2_data, u_if1.ex_imm, u_if1.ex_alu_op,
            u_if1.ex_alu_src, u_if1.ex_mem_read, u_if1.ex_mem_write,
            u_if1.ex_reg_write, u_if1.ex_mem_to_reg};
    else
      a = '{u_if3.ex_valid, u_if3.ex_pc, u_if3.ex_rs1, u_if3.ex_rs2, u_if3.ex_rd,
            u_if3.ex_rs1_data, u_if3.ex_rs2_data, u_if3.ex_imm, u_if3.ex_alu_op,
            u_if3.ex_alu_src, u_if3.ex_mem_read, u_if3.ex_mem_write,
            u_if3.ex_reg_write, u_if3.ex_mem_to_reg};
    return a;
  endfunction

  function automatic logic get_stall(int k);
    return (k == 0) ? u_if1.stall : u_if3.stall;
  endfunction

  // A load in EX blocks any dependent real instruction in ID.
  function automatic logic m_haz(int k);
    logic dep;
    dep = (cur.uses1 && cur.rs1 == m_ex[k].rd) || (cur.uses2 && cur.rs2 == m_ex[k].rd);
    return m_ex[k].valid && m_ex[k].mem_read && m_ex[k].rd != 0 && cur.valid && dep;
  endfunction

  function automatic logic m_stall(int k);
    return !cur.flush && (m_haz(k) || m_left[k] > 0);
  endfunction

  task automatic tick();
    logic h [2];
    @(posedge clk);
    for (int k = 0; k < 2; k++) h[k] = m_haz(k);
    for (int k = 0; k < 2; k++) begin
      if (cur.rst || cur.flush) begin
        m_ex[k] = '0; m_left[k] = 0;
      end else if (h[k]) begin
        m_ex[k] = '0; m_left[k] = ll[k] - 1;
      end else if (m_left[k] > 0) begin
        m_ex[k] = '0; m_left[k] = m_left[k] - 1;
      end else begin
        m_ex[k].valid = cur.valid;
        m_ex[k].pc = cur.pc;
        m_ex[k].rs1 = cur.rs1; m_ex[k].rs2 = cur.rs2; m_ex[k].rd = cur.rd;
        m_ex[k].d1 = (cur.wb_we && cur.wb_rd != 0 && cur.wb_rd == cur.rs1) ? cur.wb_data : cur.d1;
        m_ex[k].d2 = (cur.wb_we && cur.wb_rd != 0 && cur.wb_rd == cur.rs2) ? cur.wb_data : cur.d2;
        m_ex[k].imm = cur.imm;
        m_ex[k].alu_op = cur.alu_op;
        m_ex[k].alu_src = cur.valid & cur.alu_src;
        m_ex[k].mem_read = cur.valid & cur.mem_read;
        m_ex[k].mem_write = cur.valid & cur.mem_write;
        m_ex[k].reg_write = cur.valid & cur.reg_write;
        m_ex[k].mem_to_reg = cur.valid & cur.mem_to_reg;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(int n);
    cur = '0;
    apply();
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic put_load_x7();
    cur = '0;
    cur.valid = 1; cur.pc = 32'h100; cur.rs1 = 5'd1; cur.uses1 = 1; cur.rd = 5'd7;
    cur.imm = 32'd8; cur.alu_src = 1; cur.mem_read = 1; cur.reg_write = 1; cur.mem_to_reg = 1;
    apply();
    tick();
  endtask

  task automatic test_reset();
    cur = '0;
    cur.rst = 1; cur.valid = 1; cur.uses1 = 1; cur.uses2 = 1; cur.pc = 32'h44;
    cur.alu_src = 1; cur.mem_read = 1; cur.mem_write = 1; cur.reg_write = 1; cur.mem_to_reg = 1;
    cur.rd = 5'd3; cur.alu_op = 4'hF; cur.d1 = 32'h11;
    apply();
    tick(); tick();
    cur.rst = 0;
    apply();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (get_act(k) !== ex_t'(0)) begin
        n_fail++;
        $display("FAIL reset_ex[%0d] got %h want 0", k, get_act(k));
      end
      n_checks++;
      if (get_stall(k) !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_stall[%0d] got %b want 0", k, get_stall(k));
      end
    end
  endtask

  task automatic test_pass_through();
    ex_t a;
    idle(1);
    cur = '0;
    cur.valid = 1; cur.pc = 32'h40; cur.rs1 = 5'd5; cur.rs2 = 5'd6; cur.rd = 5'd10;
    cur.uses1 = 1; cur.uses2 = 1; cur.d1 = 32'd3; cur.d2 = 32'd44; cur.imm = 32'd12;
    cur.alu_op = 4'h2; cur.reg_write = 1;
    apply();
    tick();
    for (int k = 0; k < 2; k++) begin
      a = get_act(k);
      n_checks++;
      if (a.pc !== 32'h40 || a.d1 !== 32'd3 || a.d2 !== 32'd44 || a.valid !== 1'b1 ||
          a.reg_write !== 1'b1 || get_stall(k) !== 1'b0) begin
        n_fail++;
        $display("FAIL passthru_fields[%0d] got pc=%h d1=%0d d2=%0d v=%b rw=%b st=%b want pc=40 d1=3 d2=44 v=1 rw=1 st=0",
                 k, a.pc, a.d1, a.d2, a.valid, a.reg_write, get_stall(k));
      end
      n_checks++;
      if (a !== m_ex[k]) begin
        n_fail++;
        $display("FAIL passthru_ex[%0d] got %h want %h", k, a, m_ex[k]);
      end
    end
  endtask

  task automatic test_load_use();
    int   nst [2];
    ex_t  a;
    idle(4);
    put_load_x7();
    cur = '0;
    cur.valid = 1; cur.pc = 32'h104; cur.rs1 = 5'd7; cur.rs2 = 5'd3; cur.rd = 5'd8;
    cur.uses1 = 1; cur.uses2 = 1; cur.d1 = 32'h55; cur.d2 = 32'h66; cur.reg_write = 1;
    apply();
    nst[0] = 0; nst[1] = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        nst[k] += (get_stall(k) === 1'b1) ? 1 : 0;
        n_checks++;
        if (get_stall(k) !== m_stall(k)) begin
          n_fail++;
          $display("FAIL loaduse_stall[%0d] cyc %0d got %b want %b", k, c, get_stall(k), m_stall(k));
        end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        a = get_act(k);
        n_checks++;
        if (a !== m_ex[k]) begin
          n_fail++;
          $display("FAIL loaduse_ex[%0d] cyc %0d got %h want %h", k, c, a, m_ex[k]);
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (nst[k] != ll[k]) begin
        n_fail++;
        $display("FAIL loaduse_stall_cycles[%0d] got %0d want %0d", k, nst[k], ll[k]);
      end
    end
    // rs2 matches the load's rd but the instruction does not read rs2
    idle(4);
    put_load_x7();
    cur = '0;
    cur.valid = 1; cur.pc = 32'h108; cur.rs1 = 5'd3; cur.rs2 = 5'd7; cur.rd = 5'd9;
    cur.uses1 = 1; cur.uses2 = 0; cur.reg_write = 1;
    apply();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (get_stall(k) !== 1'b0) begin
        n_fail++;
        $display("FAIL no_rs2_use_stall[%0d] got %b want 0", k, get_stall(k));
      end
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (get_act(k).valid !== 1'b1 || get_act(k).rd !== 5'd9) begin
        n_fail++;
        $display("FAIL no_rs2_use_capture[%0d] got v=%b rd=%0d want v=1 rd=9", k, get_act(k).valid, get_act(k).rd);
      end
    end
  endtask

  task automatic test_bypass();
    logic [4:0]  r1 [3];
    logic [4:0]  r2 [3];
    logic [4:0]  wr [3];
    logic [31:0] e1 [3];
    logic [31:0] e2 [3];
    r1 = '{5'd9, 5'd0, 5'd9};  r2 = '{5'd9, 5'd0, 5'd4};  wr = '{5'd9, 5'd0, 5'd9};
    e1 = '{32'hDEAD, 32'd1, 32'hDEAD};  e2 = '{32'hDEAD, 32'd2, 32'd2};
    idle(1);
    for (int t = 0; t < 3; t++) begin
      cur = '0;
      cur.valid = 1; cur.pc = 32'h200 + 32'(t * 4); cur.rs1 = r1[t]; cur.rs2 = r2[t];
      cur.rd = 5'd12; cur.uses1 = 1; cur.uses2 = 1; cur.d1 = 32'd1; cur.d2 = 32'd2;
      cur.reg_write = 1; cur.wb_we = 1; cur.wb_rd = wr[t]; cur.wb_data = 32'hDEAD;
      apply();
      tick();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (get_act(k).d1 !== e1[t] || get_act(k).d2 !== e2[t]) begin
          n_fail++;
          $display("FAIL bypass[%0d] case %0d got d1=%h d2=%h want d1=%h d2=%h",
                   k, t, get_act(k).d1, get_act(k).d2, e1[t], e2[t]);
        end
      end
    end
  endtask

  task automatic test_flush();
    idle(4);
    put_load_x7();
    cur = '0;
    cur.valid = 1; cur.pc = 32'h104; cur.rs1 = 5'd7; cur.uses1 = 1; cur.rd = 5'd8;
    cur.reg_write = 1; cur.flush = 1;
    apply();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (get_stall(k) !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_stall[%0d] got %b want 0", k, get_stall(k));
      end
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (get_act(k).valid !== 1'b0 || get_act(k).reg_write !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_bubble[%0d] got v=%b rw=%b want 0 0", k, get_act(k).valid, get_act(k).reg_write);
      end
    end
    cur.flush = 0; cur.rs1 = 5'd3; cur.rs2 = 5'd4; cur.rd = 5'd5; cur.pc = 32'h300;
    apply();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (get_stall(k) !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_residual_stall[%0d] got %b want 0", k, get_stall(k));
      end
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (get_act(k) !== m_ex[k] || get_act(k).valid !== 1'b1 || get_act(k).pc !== 32'h300) begin
        n_fail++;
        $display("FAIL flush_next_capture[%0d] got %h want %h", k, get_act(k), m_ex[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      cur.rst = ($urandom_range(0, 49) == 0);
      cur.valid = ($urandom_range(0, 5) != 0);
      cur.pc = $urandom;
      cur.rs1 = 5'($urandom_range(0, 3));
      cur.rs2 = 5'($urandom_range(0, 3));
      cur.rd = 5'($urandom_range(0, 3));
      cur.uses1 = 1'($urandom);
      cur.uses2 = 1'($urandom);
      cur.d1 = $urandom; cur.d2 = $urandom; cur.imm = $urandom;
      cur.alu_op = 4'($urandom);
      cur.alu_src = 1'($urandom); cur.mem_read = 1'($urandom); cur.mem_write = 1'($urandom);
      cur.reg_write = 1'($urandom); cur.mem_to_reg = 1'($urandom);
      cur.wb_we = 1'($urandom);
      cur.wb_rd = 5'($urandom_range(0, 3));
      cur.wb_data = $urandom;
      cur.flush = ($urandom_range(0, 7) == 0);
      apply();
      #1;
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (get_stall(k) !== m_stall(k)) begin
          n_fail++;
          $display("FAIL rand_stall[%0d] cyc %0d got %b want %b", k, c, get_stall(k), m_stall(k));
        end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (get_act(k) !== m_ex[k]) begin
          n_fail++;
          $display("FAIL rand_ex[%0d] cyc %0d got %h want %h", k, c, get_act(k), m_ex[k]);
        end
      end
    end
  endtask

  initial begin
    ll[0] = 1; ll[1] = 3;
    m_ex[0] = '0; m_ex[1] = '0;
    m_left[0] = 0; m_left[1] = 0;
    test_reset();
    test_pass_through();
    test_load_use();
    test_bypass();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
